// File: rtl/sos_pkg.sv
// sos_pkg: shared definitions for the SOS letter/word sequencer.
//   sos_state_t     letter phase encoding (IDLE, S1, O, S2)
//   SYM_PER_LETTER  symbols per letter (3)
//   SOS_LEN         symbols per complete SOS (9)
//   gap_cnt_w()     gap-counter width able to hold the value TIMEOUT
package sos_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    S1   = 2'd1,
    O    = 2'd2,
    S2   = 2'd3
  } sos_state_t;

  localparam logic [1:0] SYM_PER_LETTER = 2'd3;
  localparam logic [3:0] SOS_LEN        = 4'd9;

  function automatic int unsigned gap_cnt_w(input int unsigned timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/sos_gap_timer.sv
// sos_gap_timer: saturating idle-gap counter.
//   clk, rst  clock, asynchronous active-high reset
//   clr       clear the count (symbol, collision, or sequencer idle)
//   en        count this cycle
//   expire    combinational one-cycle strobe: the count reaches TIMEOUT on
//             the coming edge; suppressed whenever clr is high
module sos_gap_timer
  import sos_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned    CW    = gap_cnt_w(TIMEOUT);
  localparam logic [CW-1:0]  LIMIT = CW'(TIMEOUT);
  localparam logic [CW-1:0]  LAST  = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = cnt_q;
    expire = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q != LIMIT) cnt_d = cnt_q + CW'(1);
      expire = (cnt_q == LAST);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sos_sequencer.sv
// sos_sequencer: recognises dot-dot-dot dash-dash-dash dot-dot-dot from
// single-cycle symbol pulses and pulses `sos` on completion.
//   clk, rst          clock, asynchronous active-high reset
//   dot_in, dash_in   one-cycle symbol pulses (both high = collision)
//   sos               registered one-cycle pulse after the 9th symbol
//   timeout           registered one-cycle pulse when a partial sequence
//                     is dropped after TIMEOUT symbol-free cycles
//   busy              state != IDLE
//   state             0 IDLE, 1 S1, 2 O, 3 S2
//   sym_cnt           symbols accumulated toward the current SOS (0..9)
// Build option: define SOS_OVERLAP_EN to reuse the trailing S of a detected
// SOS as the leading S of the next one.
module sos_sequencer
  import sos_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dot_in,
  input  logic       dash_in,
  output logic       sos,
  output logic       timeout,
  output logic       busy,
  output logic [1:0] state,
  output logic [3:0] sym_cnt
);

`ifdef SOS_OVERLAP_EN
  localparam sos_state_t POST_STATE = O;
  localparam logic [3:0] POST_CNT   = 4'd3;
`else
  localparam sos_state_t POST_STATE = IDLE;
  localparam logic [3:0] POST_CNT   = 4'd0;
`endif

  sos_state_t state_q, state_d;
  logic [1:0] lcnt_q, lcnt_d, lcnt_inc;
  logic [3:0] sym_cnt_q, sym_cnt_d, sym_base, sym_inc;
  logic       sos_q, sos_d;
  logic       timeout_q, timeout_d;
  logic       sym, coll, gap_clr, gap_expire;

  assign sym  = dot_in ^ dash_in;
  assign coll = dot_in & dash_in;

  // sym_cnt shows SOS_LEN for the cycle sos is high, while the state has
  // already moved on; the true post-detect count is substituted as the base
  // so a symbol arriving in that cycle counts from the right place.
  assign sym_base = sos_q ? POST_CNT : sym_cnt_q;
  assign sym_inc  = sym_base + 4'd1;
  assign lcnt_inc = lcnt_q + 2'd1;

  assign gap_clr = sym | coll | (state_q == IDLE);

  sos_gap_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_gap (
    .clk   (clk),
    .rst   (rst),
    .clr   (gap_clr),
    .en    (busy),
    .expire(gap_expire)
  );

  always_comb begin
    state_d   = state_q;
    lcnt_d    = lcnt_q;
    sym_cnt_d = sym_base;
    sos_d     = 1'b0;
    timeout_d = 1'b0;
    if (coll) begin
      state_d   = IDLE;
      lcnt_d    = '0;
      sym_cnt_d = '0;
    end else if (sym) begin
      case (state_q)
        IDLE: begin
          if (dot_in) begin
            state_d   = S1;
            lcnt_d    = 2'd1;
            sym_cnt_d = 4'd1;
          end
        end
        S1: begin
          if (dot_in) begin
            sym_cnt_d = sym_inc;
            if (lcnt_inc == SYM_PER_LETTER) begin
              state_d = O;
              lcnt_d  = '0;
            end else begin
              lcnt_d = lcnt_inc;
            end
          end else begin
            state_d   = IDLE;
            lcnt_d    = '0;
            sym_cnt_d = '0;
          end
        end
        O: begin
          if (dot_in) begin
            // With no dash yet, the newest three dots still form an S.
            if (lcnt_q != '0) begin
              state_d   = S1;
              lcnt_d    = 2'd1;
              sym_cnt_d = 4'd1;
            end
          end else begin
            sym_cnt_d = sym_inc;
            if (lcnt_inc == SYM_PER_LETTER) begin
              state_d = S2;
              lcnt_d  = '0;
            end else begin
              lcnt_d = lcnt_inc;
            end
          end
        end
        S2: begin
          if (dot_in) begin
            if (lcnt_inc == SYM_PER_LETTER) begin
              sos_d     = 1'b1;
              state_d   = POST_STATE;
              lcnt_d    = '0;
              sym_cnt_d = SOS_LEN;
            end else begin
              lcnt_d    = lcnt_inc;
              sym_cnt_d = sym_inc;
            end
          end else begin
            state_d   = IDLE;
            lcnt_d    = '0;
            sym_cnt_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (gap_expire) begin
      state_d   = IDLE;
      lcnt_d    = '0;
      sym_cnt_d = '0;
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      lcnt_q    <= '0;
      sym_cnt_q <= '0;
      sos_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lcnt_q    <= lcnt_d;
      sym_cnt_q <= sym_cnt_d;
      sos_q     <= sos_d;
      timeout_q <= timeout_d;
    end
  end

  assign sos     = sos_q;
  assign timeout = timeout_q;
  assign busy    = (state_q != IDLE);
  assign state   = state_q;
  assign sym_cnt = sym_cnt_q;

endmodule

// File: doc/sos_sequencer.md
# sos_sequencer

Downstream letter/word stage of the SOS detector. Consumes single-cycle dot and dash symbol pulses produced by the per-symbol detector stages and recognises the nine-symbol sequence dot-dot-dot, dash-dash-dash, dot-dot-dot (S O S). It emits a one-cycle `sos` pulse on completion. A sequence is abandoned if the symbol stream stalls longer than a programmable gap.

## Interface
- `TIMEOUT`, default 16: consecutive symbol-free cycles, while busy, before the partial sequence is dropped. Legal range is 2..255.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `dot_in` in 1: one-cycle pulse meaning one dot was recognised upstream.
- `dash_in` in 1: one-cycle pulse meaning one dash was recognised upstream.
- `sos` out 1: registered one-cycle pulse when a full SOS has been recognised.
- `timeout` out 1: registered one-cycle pulse when a partial sequence is dropped for inactivity.
- `busy` out 1: high whenever `state` is not IDLE.
- `state` out 2: current letter phase. 0 = IDLE, 1 = S1, 2 = O, 3 = S2.
- `sym_cnt` out 4: count of valid symbols accumulated toward the current SOS, range 0..9.

## Operation
- A cycle with a symbol is one where exactly one of `dot_in` or `dash_in` is high.
- A cycle with both high is a collision: go to IDLE, clear `sym_cnt` and the letter count, no pulse.
- Internal letter count `lcnt` (0..3) tracks the symbols collected for the current letter.
- Transitions on a symbol:
  - IDLE: dot → S1, lcnt=1. Dash → stay IDLE.
  - S1: dot → lcnt+1. When lcnt reaches 3, go to O with lcnt=0. Dash → IDLE.
  - O, lcnt=0: dot → stay in O, lcnt=0, `sym_cnt` held at 3. The last three dots still form an S.
  - O, lcnt>0: dot → S1, lcnt=1, `sym_cnt`=1. Dash → lcnt+1; at 3 go to S2 with lcnt=0.
  - S2: dot → lcnt+1; at 3, assert `sos` and take the post-detect transition (see Configuration). Dash → IDLE.
- `sym_cnt` increments on every accepted symbol and is set explicitly on the restart transitions above.
- Idle gap counter: cleared on any cycle with a symbol or a collision, and held at 0 while in IDLE.
  - Otherwise it increments each cycle and saturates at `TIMEOUT`.
  - On reaching `TIMEOUT`: go to IDLE, clear the counts, pulse `timeout`.
- If a symbol arrives on the same cycle the counter would expire, the symbol wins and no timeout occurs.

## Timing
- Inputs are sampled on the rising edge.
- `state`, `sym_cnt` and `busy` update on the edge that samples the symbol.
- `sos` is high for exactly the cycle following the edge that samples the 9th symbol, i.e. 1 cycle of latency.
- `timeout` is high for the cycle following the edge on which the gap count reaches `TIMEOUT`. That means exactly `TIMEOUT` symbol-free cycles after the last symbol.
- Back-to-back symbols on consecutive cycles are legal, and so are arbitrary gaps shorter than `TIMEOUT`.
- Reset values: `sos`=0, `timeout`=0, `busy`=0, `state`=0, `sym_cnt`=0, gap counter 0.
- Asserting `rst` mid-sequence clears everything immediately, with no pulse. Reception restarts on the first edge after deassertion.

## Configuration
- Macro `SOS_OVERLAP_EN`.
- Defined: after detection, the trailing S is reused as the first S of the next SOS. Next state is O, lcnt=0, `sym_cnt`=3. A following `--- ...` yields a second `sos`.
- Undefined: after detection, next state is IDLE with `sym_cnt`=0. A second SOS needs all nine symbols again.

## Structure
- Shared package `sos_pkg` holds:
  - `sos_state_t` enum: IDLE, S1, O, S2.
  - Letter length constant `SYM_PER_LETTER`=3.
  - `SOS_LEN`=9.
  - Gap-counter width derivation from `TIMEOUT`.
- Sub-module `sos_gap_timer` contains the saturating idle counter.
  - Inputs: `clk`, `rst`, `clr`, `en`.
  - Output: one-cycle `expire`.
- The FSM, `lcnt`/`sym_cnt` and output registers live in `sos_sequencer`.

## Test plan
- Reset then dots/dashes ...---... on consecutive cycles → `sos`=1 for one cycle, 1 cycle after the 9th dot. `sym_cnt` reads 9 on that edge. `timeout` never asserts.
- Same sequence with 5-cycle gaps between symbols (`TIMEOUT`=16) → `sos` pulse. Then, with a 16-cycle gap after `..` → `timeout` pulse, `state`=0, `sym_cnt`=0.
- `....---...` (four leading dots) → `sos` pulse; `sym_cnt` stays 3 after the 4th dot. `..-...---...` → S1 aborted on the dash, then `sos` on the final dot.
- `dot_in`=`dash_in`=1 on the 5th symbol → IDLE, `sym_cnt`=0, no pulse. A fresh full sequence afterwards → `sos`.
- `...---...---...`:
  - with `SOS_OVERLAP_EN` → two `sos` pulses;
  - without it → one pulse, `state`=0 after it.
- `rst` asserted asynchronously mid-O phase → all outputs 0 before the next edge. After deassertion, a full sequence → `sos`.
